// File: rtl/t07_mem_handler.sv
// ============================================================================
// Module   : t07_mem_handler
// Purpose  : Write-side front end of the register file: passes ALU results
//            through and runs a multi-cycle bus FSM for aligned loads/stores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t07_mem_handler #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    input  logic        reg_write_in,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] write_data,
    output logic [4:0]  write_reg,
    output logic        reg_write,
    output logic        freeze,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic        is_read_q, is_read_d;
    logic        err_q, err_d;

    logic        w_mem_op;
    logic        w_legal;
    logic [7:0]  w_cnt_inc;
    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [31:0] w_load_val;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;

    assign w_mem_op  = nrst && (mem_read || mem_write);
    assign w_cnt_inc = cnt_q + 8'd1;

    // Stores only accept B/H/W; both strobes high at once is never legal.
    always_comb begin
        w_legal = 1'b0;
        if (mem_read && !mem_write) begin
            case (funct3)
                c_F3_B, c_F3_BU: w_legal = 1'b1;
                c_F3_H, c_F3_HU: w_legal = !addr[0];
                c_F3_W:          w_legal = (addr[1:0] == 2'b00);
                default:         w_legal = 1'b0;
            endcase
        end else if (mem_write && !mem_read) begin
            case (funct3)
                c_F3_B:  w_legal = 1'b1;
                c_F3_H:  w_legal = !addr[0];
                c_F3_W:  w_legal = (addr[1:0] == 2'b00);
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_byte_sh = rdata_q >> {addr_q[1:0], 3'b000};
    assign w_half_sh = rdata_q >> {addr_q[1], 4'b0000};

    always_comb begin
        w_load_val = rdata_q;
        case (f3_q)
            c_F3_B:  w_load_val = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            c_F3_BU: w_load_val = {24'd0, w_byte_sh[7:0]};
            c_F3_H:  w_load_val = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            c_F3_HU: w_load_val = {16'd0, w_half_sh[15:0]};
            default: w_load_val = rdata_q;
        endcase
    end

    always_comb begin
        w_wdata = 32'd0;
        w_wstrb = 4'd0;
        if (!is_read_q) begin
            case (f3_q)
                c_F3_B: begin
                    w_wdata = {4{sdata_q[7:0]}};
                    w_wstrb = 4'b0001 << addr_q[1:0];
                end
                c_F3_H: begin
                    w_wdata = {2{sdata_q[15:0]}};
                    w_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                end
                default: begin
                    w_wdata = sdata_q;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 32'd0;
            sdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            rd_q      <= 5'd0;
            f3_q      <= 3'd0;
            is_read_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            f3_q      <= f3_d;
            is_read_q <= is_read_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        rdata_d    = rdata_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        is_read_d  = is_read_q;
        err_d      = err_q;
        bus_addr   = 32'd0;
        bus_wdata  = 32'd0;
        bus_wstrb  = 4'd0;
        bus_ren    = 1'b0;
        bus_wen    = 1'b0;
        write_data = 32'd0;
        write_reg  = 5'd0;
        reg_write  = 1'b0;
        freeze     = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_mem_op) begin
                    freeze    = 1'b1;
                    addr_d    = addr;
                    f3_d      = funct3;
                    rd_d      = rd;
                    sdata_d   = store_data;
                    is_read_d = mem_read && !mem_write;
                    err_d     = !w_legal;
                    state_d   = w_legal ? S_REQ : S_DONE;
                end else if (nrst) begin
                    write_data = alu_result;
                    write_reg  = rd;
                    reg_write  = reg_write_in;
                end
            end
            S_REQ: begin
                freeze    = 1'b1;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_wdata = w_wdata;
                bus_wstrb = w_wstrb;
                bus_ren   = is_read_q;
                bus_wen   = !is_read_q;
                cnt_d     = 8'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                freeze    = 1'b1;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_wdata = w_wdata;
                bus_wstrb = w_wstrb;
                if (!bus_busy) begin
                    rdata_d = bus_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                mem_err = err_q;
                if (is_read_q && !err_q) begin
                    reg_write  = 1'b1;
                    write_reg  = rd_q;
                    write_data = w_load_val;
                end
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
